// File: rtl/fg_bbox_tracker.sv
// rtl/fg_bbox_tracker.sv - per-frame foreground bounding box and pixel count tracker
// Follows a raster pixel stream, checks address continuity, and reports box/count once per frame.
module fg_bbox_tracker #(
   parameter int ADDR_WIDTH = 17,
   parameter int IMG_WIDTH  = 320,
   parameter int IMG_HEIGHT = 240
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  active_in,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic                  foreground_flag,
   input  logic [ADDR_WIDTH-1:0] min_count_in,
   output logic [8:0]            bbox_x_min,
   output logic [8:0]            bbox_x_max,
   output logic [7:0]            bbox_y_min,
   output logic [7:0]            bbox_y_max,
   output logic [ADDR_WIDTH-1:0] fg_count,
   output logic                  bbox_found,
   output logic                  bbox_valid,
   output logic                  sync_error
);

   typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

   localparam logic [8:0] X_LAST = 9'(IMG_WIDTH - 1);
   localparam logic [7:0] Y_LAST = 8'(IMG_HEIGHT - 1);

   state_t                state_q, state_d;
   logic [8:0]            x_q, x_d, min_x_q, min_x_d, max_x_q, max_x_d;
   logic [7:0]            y_q, y_d, min_y_q, min_y_d, max_y_q, max_y_d;
   logic [ADDR_WIDTH-1:0] exp_addr_q, exp_addr_d, count_q, count_d;
   logic                  any_fg_q, any_fg_d;
   logic [8:0]            bbox_x_min_q, bbox_x_min_d, bbox_x_max_q, bbox_x_max_d;
   logic [7:0]            bbox_y_min_q, bbox_y_min_d, bbox_y_max_q, bbox_y_max_d;
   logic [ADDR_WIDTH-1:0] fg_count_q, fg_count_d;
   logic                  bbox_found_q, bbox_found_d;
   logic                  bbox_valid_q, bbox_valid_d;
   logic                  sync_error_q, sync_error_d;

   logic                  start, accum, cur_any;
   logic [8:0]            cur_x;
   logic [7:0]            cur_y;
   logic [ADDR_WIDTH-1:0] cur_cnt, cur_exp;

   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      exp_addr_d   = exp_addr_q;
      count_d      = count_q;
      any_fg_d     = any_fg_q;
      min_x_d      = min_x_q;
      max_x_d      = max_x_q;
      min_y_d      = min_y_q;
      max_y_d      = max_y_q;
      bbox_x_min_d = bbox_x_min_q;
      bbox_x_max_d = bbox_x_max_q;
      bbox_y_min_d = bbox_y_min_q;
      bbox_y_max_d = bbox_y_max_q;
      fg_count_d   = fg_count_q;
      bbox_found_d = bbox_found_q;
      bbox_valid_d = 1'b0;
      sync_error_d = 1'b0;
      start        = 1'b0;
      accum        = 1'b0;

      case (state_q)
         IDLE: begin
            if (active_in && addr_in == '0) start = 1'b1;
         end
         ACCUM: begin
            if (active_in) begin
               if (addr_in == exp_addr_q) begin
                  accum = 1'b1;
               end else begin
                  sync_error_d = 1'b1;
                  if (addr_in == '0) start = 1'b1;
                  else               state_d = IDLE;
               end
            end
         end
         REPORT: begin
            fg_count_d   = count_q;
            bbox_found_d = any_fg_q && (count_q >= min_count_in);
            bbox_x_min_d = any_fg_q ? min_x_q : 9'd0;
            bbox_x_max_d = any_fg_q ? max_x_q : 9'd0;
            bbox_y_min_d = any_fg_q ? min_y_q : 8'd0;
            bbox_y_max_d = any_fg_q ? max_y_q : 8'd0;
            bbox_valid_d = 1'b1;
            state_d      = IDLE;
            // A frame may begin in this very cycle so back-to-back frames lose nothing
            if (active_in && addr_in == '0) start = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      cur_x   = start ? 9'd0 : x_q;
      cur_y   = start ? 8'd0 : y_q;
      cur_cnt = start ? '0 : count_q;
      cur_any = start ? 1'b0 : any_fg_q;
      cur_exp = start ? '0 : exp_addr_q;

      if (start || accum) begin
         count_d    = cur_cnt;
         any_fg_d   = cur_any;
         exp_addr_d = cur_exp + ADDR_WIDTH'(1);
         if (foreground_flag) begin
            if (!cur_any) begin
               min_x_d = cur_x;
               max_x_d = cur_x;
               min_y_d = cur_y;
               max_y_d = cur_y;
            end else begin
               if (cur_x < min_x_q) min_x_d = cur_x;
               if (cur_x > max_x_q) max_x_d = cur_x;
               if (cur_y < min_y_q) min_y_d = cur_y;
               if (cur_y > max_y_q) max_y_d = cur_y;
            end
            if (cur_cnt != '1) count_d = cur_cnt + ADDR_WIDTH'(1);
            any_fg_d = 1'b1;
         end
         if (cur_x == X_LAST) begin
            x_d = 9'd0;
            if (cur_y == Y_LAST) begin
               state_d = REPORT;
            end else begin
               y_d     = cur_y + 8'd1;
               state_d = ACCUM;
            end
         end else begin
            x_d     = cur_x + 9'd1;
            y_d     = cur_y;
            state_d = ACCUM;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         x_q          <= '0;
         y_q          <= '0;
         exp_addr_q   <= '0;
         count_q      <= '0;
         any_fg_q     <= 1'b0;
         min_x_q      <= '0;
         max_x_q      <= '0;
         min_y_q      <= '0;
         max_y_q      <= '0;
         bbox_x_min_q <= '0;
         bbox_x_max_q <= '0;
         bbox_y_min_q <= '0;
         bbox_y_max_q <= '0;
         fg_count_q   <= '0;
         bbox_found_q <= 1'b0;
         bbox_valid_q <= 1'b0;
         sync_error_q <= 1'b0;
      end else if (enable) begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         exp_addr_q   <= exp_addr_d;
         count_q      <= count_d;
         any_fg_q     <= any_fg_d;
         min_x_q      <= min_x_d;
         max_x_q      <= max_x_d;
         min_y_q      <= min_y_d;
         max_y_q      <= max_y_d;
         bbox_x_min_q <= bbox_x_min_d;
         bbox_x_max_q <= bbox_x_max_d;
         bbox_y_min_q <= bbox_y_min_d;
         bbox_y_max_q <= bbox_y_max_d;
         fg_count_q   <= fg_count_d;
         bbox_found_q <= bbox_found_d;
         bbox_valid_q <= bbox_valid_d;
         sync_error_q <= sync_error_d;
      end
   end

   assign bbox_x_min = bbox_x_min_q;
   assign bbox_x_max = bbox_x_max_q;
   assign bbox_y_min = bbox_y_min_q;
   assign bbox_y_max = bbox_y_max_q;
   assign fg_count   = fg_count_q;
   assign bbox_found = bbox_found_q;
   assign bbox_valid = bbox_valid_q;
   assign sync_error = sync_error_q;

endmodule

// File: tb/tb_fg_bbox_tracker.sv
// tb/tb_fg_bbox_tracker.sv - directed-vector bench for fg_bbox_tracker on a reduced 16x8 image
module tb_fg_bbox_tracker;

   localparam int AW = 8;
   localparam int W  = 16;
   localparam int H  = 8;
   localparam int NP = W * H;

   logic          clk = 1'b0;
   logic          rst_n, enable, active_in, foreground_flag;
   logic [AW-1:0] addr_in, min_count_in;
   logic [8:0]    bbox_x_min, bbox_x_max;
   logic [7:0]    bbox_y_min, bbox_y_max;
   logic [AW-1:0] fg_count;
   logic          bbox_found, bbox_valid, sync_error;

   fg_bbox_tracker #(.ADDR_WIDTH(AW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .active_in(active_in),
      .addr_in(addr_in), .foreground_flag(foreground_flag), .min_count_in(min_count_in),
      .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max),
      .bbox_y_min(bbox_y_min), .bbox_y_max(bbox_y_max),
      .fg_count(fg_count), .bbox_found(bbox_found),
      .bbox_valid(bbox_valid), .sync_error(sync_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      int xmin; int xmax; int ymin; int ymax; int cnt; int found; int cyc;
   } rep_t;

   rep_t rq[$];
   int   n_cmp = 0, n_bad = 0;
   int   cyc = 0, last_pix_cyc = 0, sync_cnt = 0, gap_mode = 0;
   logic en_s = 1'b0;

   always @(posedge clk) begin
      cyc  = cyc + 1;
      en_s = enable;
   end

   // Record each strobe once per enabled edge; held strobes under enable=0 are not re-counted
   always @(negedge clk) begin
      if (rst_n && en_s) begin
         if (bbox_valid) begin
            rep_t r;
            r.xmin = int'(bbox_x_min); r.xmax = int'(bbox_x_max);
            r.ymin = int'(bbox_y_min); r.ymax = int'(bbox_y_max);
            r.cnt  = int'(fg_count);   r.found = int'(bbox_found);
            r.cyc  = cyc;
            rq.push_back(r);
         end
         if (sync_error) sync_cnt = sync_cnt + 1;
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp = n_cmp + 1;
      if (obs !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit is_fg(input int mode, input int x, input int y);
      case (mode)
         1: return (x >= 3 && x <= 9 && y >= 2 && y <= 5);
         2: return ((x == 0 && y == 0) || (x == 15 && y == 7));
         3: return ((x == 5 && y == 1) || (x == 2 && y == 3) ||
                    (x == 12 && y == 6) || (x == 7 && y == 0));
         default: return 1'b0;
      endcase
   endfunction

   task automatic send_pixel(input int addr, input bit fg);
      if (gap_mode != 0) begin
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            foreground_flag = 1'b1;
            addr_in = AW'($urandom);
            if ($urandom_range(0, 1) == 1) begin
               enable = 1'b0; active_in = 1'b1;
            end else begin
               enable = 1'b1; active_in = 1'b0;
            end
         end
      end
      @(negedge clk);
      enable = 1'b1; active_in = 1'b1;
      addr_in = AW'(addr); foreground_flag = fg;
      last_pix_cyc = cyc;
      @(posedge clk);
      #1 active_in = 1'b0; foreground_flag = 1'b0;
   endtask

   task automatic send_frame(input int mode, input int from, input int to);
      for (int a = from; a <= to; a++) send_pixel(a, is_fg(mode, a % W, a / W));
   endtask

   task automatic idle(input int n);
      enable = 1'b1; active_in = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_rep(input string tag, input int xmin, input int xmax, input int ymin,
                             input int ymax, input int cnt, input int found, input bit lat);
      rep_t r;
      if (rq.size() == 0) begin
         chk({tag, "_present"}, 0, 1);
      end else begin
         r = rq.pop_front();
         chk({tag, "_xmin"}, r.xmin, xmin);
         chk({tag, "_xmax"}, r.xmax, xmax);
         chk({tag, "_ymin"}, r.ymin, ymin);
         chk({tag, "_ymax"}, r.ymax, ymax);
         chk({tag, "_cnt"}, r.cnt, cnt);
         chk({tag, "_found"}, r.found, found);
         if (lat) chk({tag, "_latency"}, r.cyc - last_pix_cyc, 2);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_xmin"}, int'(bbox_x_min), 0);
      chk({tag, "_xmax"}, int'(bbox_x_max), 0);
      chk({tag, "_ymin"}, int'(bbox_y_min), 0);
      chk({tag, "_ymax"}, int'(bbox_y_max), 0);
      chk({tag, "_cnt"}, int'(fg_count), 0);
      chk({tag, "_found"}, int'(bbox_found), 0);
      chk({tag, "_valid"}, int'(bbox_valid), 0);
      chk({tag, "_sync"}, int'(sync_error), 0);
   endtask

   int s0;

   initial begin
      rst_n = 1'b0; enable = 1'b1; active_in = 1'b0; foreground_flag = 1'b0;
      addr_in = '0; min_count_in = '0;
      #1 chk_zero("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      min_count_in = AW'(20);
      send_frame(1, 0, NP - 1); idle(4);
      chk("block_nrep", rq.size(), 1);
      expect_rep("block", 3, 9, 2, 5, 28, 1, 1);

      min_count_in = AW'(0);
      send_frame(0, 0, NP - 1); idle(4);
      expect_rep("empty", 0, 0, 0, 0, 0, 0, 1);

      min_count_in = AW'(29);
      send_frame(1, 0, NP - 1); idle(4);
      expect_rep("thr29", 3, 9, 2, 5, 28, 0, 1);
      min_count_in = AW'(28);
      send_frame(1, 0, NP - 1); idle(4);
      expect_rep("thr28", 3, 9, 2, 5, 28, 1, 1);

      min_count_in = AW'(1);
      send_frame(2, 0, NP - 1); idle(4);
      expect_rep("corner", 0, 15, 0, 7, 2, 1, 1);

      send_frame(3, 0, NP - 1);
      send_frame(1, 0, NP - 1); idle(4);
      chk("b2b_nrep", rq.size(), 2);
      expect_rep("b2b_a", 2, 12, 0, 6, 4, 1, 0);
      expect_rep("b2b_b", 3, 9, 2, 5, 28, 1, 1);

      s0 = sync_cnt;
      send_frame(1, 0, 39);
      send_frame(1, 0, NP - 1); idle(4);
      chk("restart_sync", sync_cnt - s0, 1);
      chk("restart_nrep", rq.size(), 1);
      expect_rep("restart", 3, 9, 2, 5, 28, 1, 1);

      s0 = sync_cnt;
      send_frame(1, 0, 20);
      send_frame(1, 22, NP - 1); idle(4);
      chk("skip_sync", sync_cnt - s0, 1);
      chk("skip_nrep", rq.size(), 0);
      send_frame(2, 0, NP - 1); idle(4);
      expect_rep("after_skip", 0, 15, 0, 7, 2, 1, 1);

      gap_mode = 1;
      send_frame(3, 0, NP - 1);
      gap_mode = 0;
      idle(6);
      chk("gaps_nrep", rq.size(), 1);
      expect_rep("gaps", 2, 12, 0, 6, 4, 1, 0);

      send_frame(1, 0, 50);
      @(negedge clk);
      rst_n = 1'b0;
      #1 chk_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      send_frame(1, 51, NP - 1); idle(4);
      chk("midrst_nrep", rq.size(), 0);
      send_frame(2, 0, NP - 1); idle(4);
      expect_rep("post_rst", 0, 15, 0, 7, 2, 1, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
